// File: rtl/rv32_bus_arbiter.sv
// rv32_bus_arbiter: shares one external memory bus between
// instruction fetch and the mem-stage data port.
module rv32_bus_arbiter #(
  parameter int TIMEOUT     = 255,
  parameter int COUNT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_read_in,
  input  logic [31:0] instr_address_in,
  output logic        instr_ready_out,
  output logic        instr_fault_out,
  output logic [31:0] instr_read_value_out,
  input  logic        data_read_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_address_in,
  input  logic [31:0] data_write_value_in,
  output logic        data_ready_out,
  output logic        data_fault_out,
  output logic [31:0] data_read_value_out,
  output logic        bus_valid_out,
  output logic        bus_read_out,
  output logic [3:0]  bus_write_mask_out,
  output logic [31:0] bus_address_out,
  output logic [31:0] bus_write_value_out,
  input  logic        bus_ready_in,
  input  logic [31:0] bus_read_value_in
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY_INSTR,
    S_BUSY_DATA
  } state_t;

  state_t r_state, w_state_nxt;

  logic                   r_last_data, w_last_data_nxt;
  logic [COUNT_WIDTH-1:0] r_count, w_count_nxt;

  logic        r_bus_valid, w_bus_valid_nxt;
  logic        r_bus_read, w_bus_read_nxt;
  logic [3:0]  r_bus_mask, w_bus_mask_nxt;
  logic [31:0] r_bus_addr, w_bus_addr_nxt;
  logic [31:0] r_bus_wval, w_bus_wval_nxt;

  logic        r_i_ready, w_i_ready_nxt;
  logic        r_i_fault, w_i_fault_nxt;
  logic [31:0] r_i_value, w_i_value_nxt;
  logic        r_d_ready, w_d_ready_nxt;
  logic        r_d_fault, w_d_fault_nxt;
  logic [31:0] r_d_value, w_d_value_nxt;

  logic w_data_req;
  logic w_instr_elig;
  logic w_data_elig;
  logic w_grant_data;
  logic w_grant_instr;
  logic w_timeout;

  // A port whose ready pulse is out this cycle has already been served.
  assign w_data_req    = data_read_in | (|data_write_mask_in);
  assign w_instr_elig  = instr_read_in & ~r_i_ready;
  assign w_data_elig   = w_data_req & ~r_d_ready;
  assign w_grant_data  = w_data_elig &
                         (~w_instr_elig | ~r_last_data);
  assign w_grant_instr = w_instr_elig & ~w_grant_data;
  assign w_timeout     = (TIMEOUT != 0) &&
                         (r_count == COUNT_WIDTH'(TIMEOUT));

  // Next state, bus fields and completion pulses.
  always_comb begin
    w_state_nxt     = r_state;
    w_last_data_nxt = r_last_data;
    w_count_nxt     = r_count;
    w_bus_valid_nxt = r_bus_valid;
    w_bus_read_nxt  = r_bus_read;
    w_bus_mask_nxt  = r_bus_mask;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_wval_nxt  = r_bus_wval;
    w_i_ready_nxt   = 1'b0;
    w_i_fault_nxt   = 1'b0;
    w_i_value_nxt   = 32'd0;
    w_d_ready_nxt   = 1'b0;
    w_d_fault_nxt   = 1'b0;
    w_d_value_nxt   = 32'd0;

    unique case (r_state)
      S_IDLE: begin
        if (w_grant_data) begin
          w_state_nxt     = S_BUSY_DATA;
          w_last_data_nxt = 1'b1;
          w_count_nxt     = '0;
          w_bus_valid_nxt = 1'b1;
          w_bus_read_nxt  = data_read_in;
          w_bus_mask_nxt  = data_write_mask_in;
          w_bus_addr_nxt  = data_address_in;
          w_bus_wval_nxt  = data_write_value_in;
        end else if (w_grant_instr) begin
          w_state_nxt     = S_BUSY_INSTR;
          w_last_data_nxt = 1'b0;
          w_count_nxt     = '0;
          w_bus_valid_nxt = 1'b1;
          w_bus_read_nxt  = 1'b1;
          w_bus_mask_nxt  = 4'd0;
          w_bus_addr_nxt  = instr_address_in;
        end
      end
      S_BUSY_INSTR, S_BUSY_DATA: begin
        if (bus_ready_in || w_timeout) begin
          w_state_nxt     = S_IDLE;
          w_count_nxt     = '0;
          w_bus_valid_nxt = 1'b0;
          w_bus_read_nxt  = 1'b0;
          w_bus_mask_nxt  = 4'd0;
          if (r_state == S_BUSY_INSTR) begin
            w_i_ready_nxt = 1'b1;
            w_i_fault_nxt = ~bus_ready_in;
            w_i_value_nxt = bus_ready_in ?
                            bus_read_value_in : 32'd0;
          end else begin
            w_d_ready_nxt = 1'b1;
            w_d_fault_nxt = ~bus_ready_in;
            w_d_value_nxt = (bus_ready_in && r_bus_read) ?
                            bus_read_value_in : 32'd0;
          end
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last_data <= 1'b0;
      r_count     <= '0;
      r_bus_valid <= 1'b0;
      r_bus_read  <= 1'b0;
      r_bus_mask  <= 4'd0;
      r_bus_addr  <= 32'd0;
      r_bus_wval  <= 32'd0;
      r_i_ready   <= 1'b0;
      r_i_fault   <= 1'b0;
      r_i_value   <= 32'd0;
      r_d_ready   <= 1'b0;
      r_d_fault   <= 1'b0;
      r_d_value   <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_data <= w_last_data_nxt;
      r_count     <= w_count_nxt;
      r_bus_valid <= w_bus_valid_nxt;
      r_bus_read  <= w_bus_read_nxt;
      r_bus_mask  <= w_bus_mask_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_wval  <= w_bus_wval_nxt;
      r_i_ready   <= w_i_ready_nxt;
      r_i_fault   <= w_i_fault_nxt;
      r_i_value   <= w_i_value_nxt;
      r_d_ready   <= w_d_ready_nxt;
      r_d_fault   <= w_d_fault_nxt;
      r_d_value   <= w_d_value_nxt;
    end
  end

  assign instr_ready_out      = r_i_ready;
  assign instr_fault_out      = r_i_fault;
  assign instr_read_value_out = r_i_value;
  assign data_ready_out       = r_d_ready;
  assign data_fault_out       = r_d_fault;
  assign data_read_value_out  = r_d_value;
  assign bus_valid_out        = r_bus_valid;
  assign bus_read_out         = r_bus_read;
  assign bus_write_mask_out   = r_bus_mask;
  assign bus_address_out      = r_bus_addr;
  assign bus_write_value_out  = r_bus_wval;

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// tb_rv32_bus_arbiter: random fetch/data traffic checked
// against a transaction-schedule model of the arbiter.
module tb_rv32_bus_arbiter;

  localparam int T = 4;
  localparam int N = 1500;
  localparam int M = N + 20;

  logic        clk;
  logic        reset;
  logic        instr_read_in;
  logic [31:0] instr_address_in;
  logic        instr_ready_out;
  logic        instr_fault_out;
  logic [31:0] instr_read_value_out;
  logic        data_read_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_address_in;
  logic [31:0] data_write_value_in;
  logic        data_ready_out;
  logic        data_fault_out;
  logic [31:0] data_read_value_out;
  logic        bus_valid_out;
  logic        bus_read_out;
  logic [3:0]  bus_write_mask_out;
  logic [31:0] bus_address_out;
  logic [31:0] bus_write_value_out;
  logic        bus_ready_in;
  logic [31:0] bus_read_value_in;

  rv32_bus_arbiter #(.TIMEOUT(T), .COUNT_WIDTH(8)) dut (
    .clk                  (clk),
    .reset                (reset),
    .instr_read_in        (instr_read_in),
    .instr_address_in     (instr_address_in),
    .instr_ready_out      (instr_ready_out),
    .instr_fault_out      (instr_fault_out),
    .instr_read_value_out (instr_read_value_out),
    .data_read_in         (data_read_in),
    .data_write_mask_in   (data_write_mask_in),
    .data_address_in      (data_address_in),
    .data_write_value_in  (data_write_value_in),
    .data_ready_out       (data_ready_out),
    .data_fault_out       (data_fault_out),
    .data_read_value_out  (data_read_value_out),
    .bus_valid_out        (bus_valid_out),
    .bus_read_out         (bus_read_out),
    .bus_write_mask_out   (bus_write_mask_out),
    .bus_address_out      (bus_address_out),
    .bus_write_value_out  (bus_write_value_out),
    .bus_ready_in         (bus_ready_in),
    .bus_read_value_in    (bus_read_value_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total;
  int bad;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " valid"}, 32'(bus_valid_out), 0);
    check_eq({tag, " read"}, 32'(bus_read_out), 0);
    check_eq({tag, " mask"}, 32'(bus_write_mask_out), 0);
    check_eq({tag, " addr"}, bus_address_out, 0);
    check_eq({tag, " wval"}, bus_write_value_out, 0);
    check_eq({tag, " i_rdy"}, 32'(instr_ready_out), 0);
    check_eq({tag, " i_flt"}, 32'(instr_fault_out), 0);
    check_eq({tag, " i_val"}, instr_read_value_out, 0);
    check_eq({tag, " d_rdy"}, 32'(data_ready_out), 0);
    check_eq({tag, " d_flt"}, 32'(data_fault_out), 0);
    check_eq({tag, " d_val"}, data_read_value_out, 0);
  endtask

  // Expected per-cycle outputs, filled when a launch is predicted.
  bit          e_valid [M];
  bit          e_read  [M];
  logic [3:0]  e_mask  [M];
  logic [31:0] e_addr  [M];
  logic [31:0] e_wval  [M];
  bit          e_wvset [M];
  bit          e_ir    [M];
  bit          e_if    [M];
  logic [31:0] e_iv    [M];
  bit          e_dr    [M];
  bit          e_df    [M];
  logic [31:0] e_dv    [M];

  // Requester agents.
  bit          i_act, d_act, d_rd;
  logic [31:0] i_addr, d_addr, d_wval;
  logic [3:0]  d_mask;
  int          i_start, d_start, i_done, d_done;

  // Arbiter model.
  int          free_cyc;
  bit          last_data;
  int          rdy_cyc;
  logic [31:0] rdy_val;
  logic [31:0] hold_addr, hold_wval;

  function automatic int pick_gap();
    return ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
  endfunction

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return r % 4;
    if (r == 6) return T;
    if (r <= 8) return $urandom_range(T + 1, T + 3);
    return 0;
  endfunction

  task automatic launch(input bit is_data, input int c);
    int w, k, p;
    logic [31:0] v;
    w = pick_wait();
    k = (w <= T) ? w + 1 : T + 1;
    p = c + 1 + k;
    for (int j = c + 1; j <= c + k; j++) begin
      e_valid[j] = 1'b1;
      e_read[j]  = is_data ? d_rd : 1'b1;
      e_mask[j]  = is_data ? d_mask : 4'd0;
      e_addr[j]  = is_data ? d_addr : i_addr;
      e_wval[j]  = d_wval;
      e_wvset[j] = is_data;
    end
    if (w <= T) begin
      rdy_cyc = c + 1 + w;
      rdy_val = $urandom;
      v = (!is_data || d_rd) ? rdy_val : 32'd0;
    end else begin
      rdy_cyc = -1;
      v = 32'd0;
    end
    if (is_data) begin
      e_dr[p] = 1'b1;
      e_df[p] = (w > T);
      e_dv[p] = v;
      d_done  = p;
    end else begin
      e_ir[p] = 1'b1;
      e_if[p] = (w > T);
      e_iv[p] = v;
      i_done  = p;
    end
    free_cyc  = p;
    last_data = is_data;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    instr_read_in       = 1'b0;
    instr_address_in    = 32'd0;
    data_read_in        = 1'b0;
    data_write_mask_in  = 4'd0;
    data_address_in     = 32'd0;
    data_write_value_in = 32'd0;
    bus_ready_in        = 1'b0;
    bus_read_value_in   = 32'd0;
    for (int j = 0; j < M; j++) begin
      e_mask[j] = 4'd0;
      e_addr[j] = 32'd0;
      e_wval[j] = 32'd0;
      e_iv[j]   = 32'd0;
      e_dv[j]   = 32'd0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset");

    // Data read abandoned by reset while the bus is stalled.
    @(posedge clk); #1;
    data_read_in    = 1'b1;
    data_address_in = 32'h40;
    @(posedge clk); #1;
    check_eq("midop valid c1", 32'(bus_valid_out), 1);
    @(posedge clk); #1;
    check_eq("midop valid c2", 32'(bus_valid_out), 1);
    reset = 1'b1;
    #1;
    check_all_zero("async");
    data_read_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check_eq("post d_rdy", 32'(data_ready_out), 0);
      check_eq("post valid", 32'(bus_valid_out), 0);
    end

    i_act = 0; d_act = 0; d_rd = 0;
    i_addr = 0; d_addr = 0; d_wval = 0; d_mask = 0;
    i_start = $urandom_range(0, 2);
    d_start = $urandom_range(0, 2);
    i_done = -10; d_done = -10;
    free_cyc = 0; last_data = 0; rdy_cyc = -1; rdy_val = 0;
    hold_addr = 0; hold_wval = 0;

    for (int c = 0; c < N; c++) begin
      bit ie, de;
      int kind;
      @(posedge clk); #1;
      if (i_done == c - 1) begin
        i_act = 0;
        i_start = c + pick_gap();
      end
      if (d_done == c - 1) begin
        d_act = 0;
        d_start = c + pick_gap();
      end
      if (!i_act && c >= i_start) begin
        i_act  = 1;
        i_addr = $urandom;
      end
      if (!d_act && c >= d_start) begin
        d_act  = 1;
        d_addr = $urandom;
        d_wval = $urandom;
        kind   = $urandom_range(0, 3);
        d_rd   = (kind != 2);
        d_mask = (kind >= 2) ? 4'($urandom_range(1, 15)) : 4'd0;
      end
      instr_read_in       = i_act;
      instr_address_in    = i_act ? i_addr : $urandom;
      data_read_in        = d_act & d_rd;
      data_write_mask_in  = d_act ? d_mask : 4'd0;
      data_address_in     = d_act ? d_addr : $urandom;
      data_write_value_in = d_act ? d_wval : $urandom;
      bus_ready_in        = (c == rdy_cyc);
      bus_read_value_in   = (c == rdy_cyc) ? rdy_val : $urandom;
      if (c >= free_cyc) begin
        ie = i_act && !e_ir[c];
        de = d_act && !e_dr[c];
        if (de && (!ie || !last_data)) launch(1'b1, c);
        else if (ie) launch(1'b0, c);
      end

      @(negedge clk);
      if (e_valid[c]) begin
        hold_addr = e_addr[c];
        if (e_wvset[c]) hold_wval = e_wval[c];
      end
      check_eq("bus_valid", 32'(bus_valid_out), 32'(e_valid[c]));
      check_eq("bus_read", 32'(bus_read_out), 32'(e_read[c]));
      check_eq("bus_mask", 32'(bus_write_mask_out), 32'(e_mask[c]));
      check_eq("bus_addr", bus_address_out, hold_addr);
      check_eq("bus_wval", bus_write_value_out, hold_wval);
      check_eq("i_ready", 32'(instr_ready_out), 32'(e_ir[c]));
      check_eq("i_fault", 32'(instr_fault_out), 32'(e_if[c]));
      check_eq("i_value", instr_read_value_out, e_iv[c]);
      check_eq("d_ready", 32'(data_ready_out), 32'(e_dr[c]));
      check_eq("d_fault", 32'(data_fault_out), 32'(e_df[c]));
      check_eq("d_value", data_read_value_out, e_dv[c]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
